// File: rtl/miriscv_instr_decoder_if.sv
// Decode-stage bundle: fetched instruction in, decoded control fields out.
interface miriscv_instr_decoder_if;
  localparam int ALU_OP_WIDTH = 5;

  logic [31:0]             fetched_instr_i;
  logic [1:0]              ex_op_a_sel_o;
  logic [2:0]              ex_op_b_sel_o;
  logic [ALU_OP_WIDTH-1:0] alu_op_o;
  logic                    mem_req_o;
  logic                    mem_we_o;
  logic [2:0]              mem_size_o;
  logic                    gpr_we_a_o;
  logic                    wb_src_sel_o;
  logic                    illegal_instr_o;
  logic                    branch_o;
  logic                    jal_o;
  logic                    jalr_o;

  modport master (
    output fetched_instr_i,
    input  ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o,
    input  mem_req_o, mem_we_o, mem_size_o,
    input  gpr_we_a_o, wb_src_sel_o, illegal_instr_o,
    input  branch_o, jal_o, jalr_o
  );

  modport slave (
    input  fetched_instr_i,
    output ex_op_a_sel_o, ex_op_b_sel_o, alu_op_o,
    output mem_req_o, mem_we_o, mem_size_o,
    output gpr_we_a_o, wb_src_sel_o, illegal_instr_o,
    output branch_o, jal_o, jalr_o
  );
endinterface

// File: rtl/miriscv_instr_decoder.sv
// RV32I main decoder: combinational instruction-to-control mapping,
// outputs held at zero while the async reset is asserted.
module miriscv_instr_decoder (
  input logic                    clk_i,
  input logic                    arstn_i,
  miriscv_instr_decoder_if.slave dec
);
  localparam logic [4:0] OPC_LOAD  = 5'b00000;
  localparam logic [4:0] OPC_MISC  = 5'b00011;
  localparam logic [4:0] OPC_OPIMM = 5'b00100;
  localparam logic [4:0] OPC_AUIPC = 5'b00101;
  localparam logic [4:0] OPC_STORE = 5'b01000;
  localparam logic [4:0] OPC_OP    = 5'b01100;
  localparam logic [4:0] OPC_LUI   = 5'b01101;
  localparam logic [4:0] OPC_BR    = 5'b11000;
  localparam logic [4:0] OPC_JALR  = 5'b11001;
  localparam logic [4:0] OPC_JAL   = 5'b11011;
  localparam logic [4:0] OPC_SYS   = 5'b11100;

  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b01000;
  localparam logic [4:0] ALU_SRL = 5'b00101;
  localparam logic [4:0] ALU_SRA = 5'b01101;

  localparam logic [1:0] A_RS1  = 2'd0;
  localparam logic [1:0] A_PC   = 2'd1;
  localparam logic [1:0] A_ZERO = 2'd2;

  localparam logic [2:0] B_RS2  = 3'd0;
  localparam logic [2:0] B_IMMI = 3'd1;
  localparam logic [2:0] B_IMMU = 3'd2;
  localparam logic [2:0] B_IMMS = 3'd3;
  localparam logic [2:0] B_INCR = 3'd4;

  logic unused_clk;
  assign unused_clk = clk_i;

  logic [31:0] instr;
  logic [4:0]  opc;
  logic [2:0]  f3;
  logic [6:0]  f7;

  assign instr = dec.fetched_instr_i;
  assign opc   = instr[6:2];
  assign f3    = instr[14:12];
  assign f7    = instr[31:25];

  logic [1:0] a_sel;
  logic [2:0] b_sel;
  logic [4:0] alu;
  logic       req;
  logic       we;
  logic [2:0] size;
  logic       gpr;
  logic       wb;
  logic       ill;
  logic       br;
  logic       jal;
  logic       jalr;

  always_comb begin
    a_sel = A_RS1;
    b_sel = B_RS2;
    alu   = ALU_ADD;
    req   = 1'b0;
    we    = 1'b0;
    size  = 3'd0;
    gpr   = 1'b0;
    wb    = 1'b0;
    ill   = 1'b0;
    br    = 1'b0;
    jal   = 1'b0;
    jalr  = 1'b0;
    if (instr[1:0] != 2'b11) begin
      ill = 1'b1;
    end else begin
      case (opc)
        OPC_OP: begin
          gpr = 1'b1;
          if (f7 == 7'h00) alu = {2'b00, f3};
          else if (f7 == 7'h20 && f3 == 3'b000) alu = ALU_SUB;
          else if (f7 == 7'h20 && f3 == 3'b101) alu = ALU_SRA;
          else ill = 1'b1;
        end
        OPC_OPIMM: begin
          b_sel = B_IMMI;
          gpr   = 1'b1;
          alu   = {2'b00, f3};
          // shift-immediates carry funct7 in the upper immediate bits
          if (f3 == 3'b001 && f7 != 7'h00) ill = 1'b1;
          if (f3 == 3'b101) begin
            if (f7 == 7'h00) alu = ALU_SRL;
            else if (f7 == 7'h20) alu = ALU_SRA;
            else ill = 1'b1;
          end
        end
        OPC_LOAD: begin
          b_sel = B_IMMI;
          req   = 1'b1;
          size  = f3;
          gpr   = 1'b1;
          wb    = 1'b1;
          if (f3 == 3'b011 || f3[2:1] == 2'b11) ill = 1'b1;
        end
        OPC_STORE: begin
          b_sel = B_IMMS;
          req   = 1'b1;
          we    = 1'b1;
          size  = f3;
          if (f3 > 3'b010) ill = 1'b1;
        end
        OPC_BR: begin
          br  = 1'b1;
          alu = {2'b11, f3};
          if (f3[2:1] == 2'b01) ill = 1'b1;
        end
        OPC_JAL: begin
          a_sel = A_PC;
          b_sel = B_INCR;
          gpr   = 1'b1;
          jal   = 1'b1;
        end
        OPC_JALR: begin
          a_sel = A_PC;
          b_sel = B_INCR;
          gpr   = 1'b1;
          jalr  = 1'b1;
          if (f3 != 3'b000) ill = 1'b1;
        end
        OPC_LUI: begin
          a_sel = A_ZERO;
          b_sel = B_IMMU;
          gpr   = 1'b1;
        end
        OPC_AUIPC: begin
          a_sel = A_PC;
          b_sel = B_IMMU;
          gpr   = 1'b1;
        end
        OPC_MISC: begin
          if (f3 != 3'b000) ill = 1'b1;
        end
        OPC_SYS: begin
          if (instr != 32'h0000_0073 && instr != 32'h0010_0073)
            ill = 1'b1;
        end
        default: ill = 1'b1;
      endcase
    end
    if (ill) begin
      req  = 1'b0;
      we   = 1'b0;
      gpr  = 1'b0;
      br   = 1'b0;
      jal  = 1'b0;
      jalr = 1'b0;
    end
  end

  // reset gating is combinational so outputs clear the instant arstn_i drops
  always_comb begin
    dec.ex_op_a_sel_o   = arstn_i ? a_sel : 2'd0;
    dec.ex_op_b_sel_o   = arstn_i ? b_sel : 3'd0;
    dec.alu_op_o        = arstn_i ? alu   : ALU_ADD;
    dec.mem_req_o       = arstn_i & req;
    dec.mem_we_o        = arstn_i & we;
    dec.mem_size_o      = arstn_i ? size  : 3'd0;
    dec.gpr_we_a_o      = arstn_i & gpr;
    dec.wb_src_sel_o    = arstn_i & wb;
    dec.illegal_instr_o = arstn_i & ill;
    dec.branch_o        = arstn_i & br;
    dec.jal_o           = arstn_i & jal;
    dec.jalr_o          = arstn_i & jalr;
  end
endmodule

// File: tb/tb_miriscv_instr_decoder.sv
// Directed bench for miriscv_instr_decoder with an expected-value queue.
module tb_miriscv_instr_decoder;
  logic clk;
  logic arstn;
  int   checks;
  int   errors;

  miriscv_instr_decoder_if dif ();

  miriscv_instr_decoder dut (
    .clk_i   (clk),
    .arstn_i (arstn),
    .dec     (dif.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    logic [20:0] exp;
    logic [20:0] mask;
  } sb_t;

  sb_t sb_q[$];

  localparam logic [20:0] M_ALL = 21'h1FFFFF;
  localparam logic [20:0] M_ILL = 21'h00062F;

  function automatic logic [20:0] ev(
    input logic [1:0] a, input logic [2:0] b, input logic [4:0] alu,
    input logic req, input logic we, input logic [2:0] sz,
    input logic gpr, input logic wb, input logic ill,
    input logic br, input logic jal, input logic jalr);
    return {a, b, alu, req, we, sz, gpr, wb, ill, br, jal, jalr};
  endfunction

  function automatic logic [20:0] obs();
    return {dif.ex_op_a_sel_o, dif.ex_op_b_sel_o, dif.alu_op_o,
            dif.mem_req_o, dif.mem_we_o, dif.mem_size_o,
            dif.gpr_we_a_o, dif.wb_src_sel_o, dif.illegal_instr_o,
            dif.branch_o, dif.jal_o, dif.jalr_o};
  endfunction

  task automatic check_out();
    sb_t e;
    logic [20:0] got;
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL sb_empty got=%0d required=1", sb_q.size());
      return;
    end
    e   = sb_q.pop_front();
    got = obs();
    checks++;
    assert ((got & e.mask) === (e.exp & e.mask)) else begin
      errors++;
      $error("FAIL %s got=%06h required=%06h mask=%06h",
             e.tag, got, e.exp, e.mask);
    end
  endtask

  task automatic step(input string tag, input logic [31:0] instr,
                      input logic [20:0] exp, input logic [20:0] mask);
    sb_t e;
    @(negedge clk);
    dif.fetched_instr_i = instr;
    e.tag  = tag;
    e.exp  = exp;
    e.mask = mask;
    sb_q.push_back(e);
    #2;
    check_out();
  endtask

  initial begin
    checks = 0;
    errors = 0;
    arstn  = 1'b0;
    dif.fetched_instr_i = 32'h0;

    step("reset_idle", 32'h0000_0000, ev(0,0,0,0,0,0,0,0,0,0,0,0), M_ALL);
    step("reset_ori",  32'h28F2_E813, ev(0,0,0,0,0,0,0,0,0,0,0,0), M_ALL);

    @(negedge clk);
    arstn = 1'b1;

    step("ori",      32'h28F2_E813, ev(0,1,5'b00110,0,0,0,1,0,0,0,0,0), M_ALL);
    step("sub",      32'h40B5_0533, ev(0,0,5'b01000,0,0,0,1,0,0,0,0,0), M_ALL);
    step("sra",      32'h40B5_5533, ev(0,0,5'b01101,0,0,0,1,0,0,0,0,0), M_ALL);
    step("op_f7bad", 32'h02B5_0533, ev(0,0,0,0,0,0,0,0,1,0,0,0), M_ILL);
    step("lw",       32'h0045_2283, ev(0,1,0,1,0,2,1,1,0,0,0,0), M_ALL);
    step("sw",       32'h0055_2223, ev(0,3,0,1,1,2,0,0,0,0,0,0), M_ALL);
    step("ld_f3_3",  32'h0045_3283, ev(0,0,0,0,0,0,0,0,1,0,0,0), M_ILL);
    step("st_f3_3",  32'h0055_3223, ev(0,0,0,0,0,0,0,0,1,0,0,0), M_ILL);
    step("beq",      32'hFE20_8EE3, ev(0,0,5'b11000,0,0,0,0,0,0,1,0,0), M_ALL);
    step("bltu",     32'h0020_E463, ev(0,0,5'b11110,0,0,0,0,0,0,1,0,0), M_ALL);
    step("br_f3_2",  32'h0020_A463, ev(0,0,0,0,0,0,0,0,1,0,0,0), M_ILL);
    step("jal",      32'h0080_00EF, ev(1,4,0,0,0,0,1,0,0,0,1,0), M_ALL);
    step("jalr",     32'h0000_80E7, ev(1,4,0,0,0,0,1,0,0,0,0,1), M_ALL);
    step("lui",      32'h1234_50B7, ev(2,2,0,0,0,0,1,0,0,0,0,0), M_ALL);
    step("auipc",    32'h1234_5097, ev(1,2,0,0,0,0,1,0,0,0,0,0), M_ALL);
    step("srai",     32'h4050_D093, ev(0,1,5'b01101,0,0,0,1,0,0,0,0,0), M_ALL);
    step("slli_bad", 32'h4010_9093, ev(0,0,0,0,0,0,0,0,1,0,0,0), M_ILL);
    step("ecall",    32'h0000_0073, ev(0,0,0,0,0,0,0,0,0,0,0,0), M_ALL);
    step("ebreak",   32'h0010_0073, ev(0,0,0,0,0,0,0,0,0,0,0,0), M_ALL);
    step("sys_bad",  32'h0020_0073, ev(0,0,0,0,0,0,0,0,1,0,0,0), M_ILL);
    step("fence",    32'h0000_000F, ev(0,0,0,0,0,0,0,0,0,0,0,0), M_ALL);
    step("zero",     32'h0000_0000, ev(0,0,0,0,0,0,0,0,1,0,0,0), M_ALL);

    // mid-cycle reset assertion with a live instruction
    step("pre_rst",  32'h28F2_E813, ev(0,1,5'b00110,0,0,0,1,0,0,0,0,0), M_ALL);
    arstn = 1'b0;
    sb_q.push_back('{"async_rst", ev(0,0,0,0,0,0,0,0,0,0,0,0), M_ALL});
    #1;
    check_out();
    arstn = 1'b1;
    sb_q.push_back('{"rst_release", ev(0,1,5'b00110,0,0,0,1,0,0,0,0,0), M_ALL});
    #1;
    check_out();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
